// File: rtl/instr_fetch_unit.sv
// Program-sequencing stage: small loadable instruction memory that streams words
// to the core over a valid/ready handshake, resolving JMP and HALT locally.
module instr_fetch_unit #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [7:0]    load_data,
   input  logic          start,
   input  logic          instr_ready,
   output logic [7:0]    instr,
   output logic          instr_valid,
   output logic [AW-1:0] pc,
   output logic          busy,
   output logic          halted,
   output logic [7:0]    instr_count
);

   localparam logic [7:0]    HALT_WORD = 8'h0F;
   localparam logic [3:0]    JMP_OP    = 4'hF;
   localparam logic [AW-1:0] PC_LAST   = AW'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   state_t     state;
   logic [7:0] mem [DEPTH];

   logic [7:0] word_c;
   logic       advance_c;
   logic       xfer_c;
   logic       is_halt_c;
   logic       is_jmp_c;

   assign word_c    = mem[pc];
   assign advance_c = !instr_valid || instr_ready;
   assign xfer_c    = instr_valid && instr_ready;
   assign is_halt_c = (word_c == HALT_WORD);
   assign is_jmp_c  = (word_c[7:4] == JMP_OP);

   // Program memory has no reset so a loaded program survives rst.
   always_ff @(posedge clk) begin
      if (load_en && (state != RUN)) begin
         mem[load_addr] <= load_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         instr       <= 8'h00;
         instr_valid <= 1'b0;
         pc          <= '0;
         busy        <= 1'b0;
         halted      <= 1'b0;
         instr_count <= 8'h00;
      end else begin
         case (state)
            IDLE, HALT: begin
               if (start) begin
                  state       <= RUN;
                  pc          <= '0;
                  instr_count <= 8'h00;
                  instr       <= 8'h00;
                  instr_valid <= 1'b0;
                  busy        <= 1'b1;
                  halted      <= 1'b0;
               end
            end
            RUN: begin
               if (xfer_c && (instr_count != 8'hFF)) begin
                  instr_count <= instr_count + 8'd1;
               end
               // The slot is refilled whenever it is empty or being consumed.
               if (advance_c) begin
                  if (is_halt_c) begin
                     state       <= HALT;
                     instr       <= 8'h00;
                     instr_valid <= 1'b0;
                     busy        <= 1'b0;
                     halted      <= 1'b1;
                  end else if (is_jmp_c) begin
                     pc          <= word_c[AW-1:0];
                     instr       <= 8'h00;
                     instr_valid <= 1'b0;
                  end else begin
                     instr       <= word_c;
                     instr_valid <= 1'b1;
                     pc          <= (pc == PC_LAST) ? '0 : pc + AW'(1);
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: cycle-level reference model compared every cycle,
// plus directed programs with hand-computed expectations.
module tb_instr_fetch_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       load_en;
   logic [3:0] load_addr;
   logic [7:0] load_data;
   logic       start;
   logic       instr_ready;
   logic [7:0] instr;
   logic       instr_valid;
   logic [3:0] pc;
   logic       busy;
   logic       halted;
   logic [7:0] instr_count;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   instr_fetch_unit #(.DEPTH(16), .AW(4)) dut (
      .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .start(start), .instr_ready(instr_ready),
      .instr(instr), .instr_valid(instr_valid), .pc(pc), .busy(busy),
      .halted(halted), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: mode 0=idle 1=run 2=halt; count kept unsaturated.
   logic [7:0] m_mem [16];
   int         m_mode, m_pc, m_cnt;
   logic [7:0] m_instr;
   bit         m_valid;
   logic [7:0] w;

   always @(posedge clk) begin
      if (rst) begin
         m_mode = 0; m_pc = 0; m_cnt = 0; m_instr = 8'h00; m_valid = 0;
      end else if (m_mode != 1) begin
         if (load_en) m_mem[load_addr] = load_data;
         if (start) begin
            m_mode = 1; m_pc = 0; m_cnt = 0; m_instr = 8'h00; m_valid = 0;
         end
      end else begin
         if (m_valid && instr_ready) m_cnt++;
         if (!m_valid || instr_ready) begin
            w = m_mem[m_pc];
            if (w == 8'h0F) begin
               m_mode = 2; m_valid = 0; m_instr = 8'h00;
            end else if (w[7:4] == 4'hF) begin
               m_pc = int'(w[3:0]); m_valid = 0; m_instr = 8'h00;
            end else begin
               m_instr = w; m_valid = 1; m_pc = (m_pc + 1) % 16;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("instr", int'(instr), int'(m_instr));
         chk("valid", int'(instr_valid), int'(m_valid));
         chk("pc", int'(pc), m_pc);
         chk("busy", int'(busy), int'(m_mode == 1));
         chk("halted", int'(halted), int'(m_mode == 2));
         chk("count", int'(instr_count), (m_cnt > 255) ? 255 : m_cnt);
      end
   end

   // Log of words actually transferred to the core.
   logic [7:0] xq [$];
   always @(posedge clk) begin
      if (!rst && instr_valid && instr_ready) xq.push_back(instr);
   end

   task automatic load(input logic [3:0] a, input logic [7:0] d);
      load_en = 1'b1; load_addr = a; load_data = d;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_halt(input string name);
      for (int i = 0; i < 60 && !halted; i++) @(negedge clk);
      chk(name, int'(halted), 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
      start = 1'b0; instr_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      chk("rst_valid", int'(instr_valid), 0);
      chk("rst_pc", int'(pc), 0);
      chk("rst_count", int'(instr_count), 0);

      // Straight-line program ending in HALT
      load(4'd0, 8'h10); load(4'd1, 8'h20); load(4'd2, 8'h30); load(4'd3, 8'h0F);
      xq.delete();
      pulse_start();
      chk("t1_lat_valid0", int'(instr_valid), 0);
      @(negedge clk);
      chk("t1_first_valid", int'(instr_valid), 1);
      chk("t1_first_instr", int'(instr), 8'h10);
      wait_halt("t1_halt");
      chk("t1_count", int'(instr_count), 3);
      chk("t1_pc", int'(pc), 3);
      chk("t1_nxfer", xq.size(), 3);
      if (xq.size() == 3) begin
         chk("t1_x0", int'(xq[0]), 8'h10);
         chk("t1_x1", int'(xq[1]), 8'h20);
         chk("t1_x2", int'(xq[2]), 8'h30);
      end

      // Same program with a 3-cycle stall on 8'h20
      xq.delete();
      pulse_start();
      for (int i = 0; i < 10 && !(instr_valid && instr == 8'h20); i++) @(negedge clk);
      chk("t2_reach20", int'(instr), 8'h20);
      instr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t2_stall_instr", int'(instr), 8'h20);
         chk("t2_stall_valid", int'(instr_valid), 1);
         chk("t2_stall_pc", int'(pc), 2);
         chk("t2_stall_count", int'(instr_count), 1);
      end
      instr_ready = 1'b1;
      wait_halt("t2_halt");
      chk("t2_count", int'(instr_count), 3);
      chk("t2_nxfer", xq.size(), 3);
      if (xq.size() == 3) chk("t2_x1", int'(xq[1]), 8'h20);

      // Jump with one bubble
      load(4'd1, 8'hF4); load(4'd4, 8'h90); load(4'd5, 8'h0F);
      xq.delete();
      pulse_start();
      @(negedge clk);
      chk("t3_i0", int'(instr), 8'h10);
      @(negedge clk);
      chk("t3_bubble_valid", int'(instr_valid), 0);
      chk("t3_bubble_pc", int'(pc), 4);
      @(negedge clk);
      chk("t3_i1", int'(instr), 8'h90);
      chk("t3_i1_valid", int'(instr_valid), 1);
      wait_halt("t3_halt");
      chk("t3_count", int'(instr_count), 2);

      // Endless loop via wrap jump; count saturates
      for (int a = 0; a < 15; a++) load(4'(a), 8'h50);
      load(4'd15, 8'hF0);
      xq.delete();
      pulse_start();
      repeat (300) @(negedge clk);
      chk("t4_sat", int'(instr_count), 255);
      chk("t4_busy", int'(busy), 1);
      chk("t4_many", int'(xq.size() >= 256), 1);

      // Reset mid-run drops the pending word; memory kept
      chk("t5_pre_valid", int'(instr_valid), 1);
      do_reset();
      chk("t5_instr", int'(instr), 0);
      chk("t5_valid", int'(instr_valid), 0);
      chk("t5_pc", int'(pc), 0);
      chk("t5_busy", int'(busy), 0);
      pulse_start();
      @(negedge clk);
      chk("t5_replay", int'(instr), 8'h50);
      do_reset();

      // Loads during RUN ignored; load+start together in HALT takes effect
      load(4'd0, 8'h10); load(4'd1, 8'h0F);
      instr_ready = 1'b0;
      pulse_start();
      load(4'd0, 8'hE0);
      instr_ready = 1'b1;
      wait_halt("t6_halt_a");
      pulse_start();
      @(negedge clk);
      chk("t6_mem_kept", int'(instr), 8'h10);
      wait_halt("t6_halt_b");
      load_en = 1'b1; load_addr = 4'd0; load_data = 8'hE0; start = 1'b1;
      @(negedge clk);
      load_en = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("t6_new_first", int'(instr), 8'hE0);
      wait_halt("t6_halt_c");
      chk("t6_count", int'(instr_count), 1);

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Program-sequencing stage directly upstream of the processor core; drives the core's 8-bit `instr` input.
- Holds a small instruction memory, loaded through a write port while idle.
- After `start`, issues one instruction per accepted handshake.
- Resolves jump and halt words locally; neither is ever forwarded to the core.

Parameters:
DEPTH, 16, number of 8-bit instruction words in program memory.
AW, 4, address/PC width; must equal clog2(DEPTH).

Ports:
clk  input  1  single clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
load_en  input  1  write load_data into mem[load_addr]; honoured only in IDLE or HALT.
load_addr  input  AW  program memory write address.
load_data  input  8  program word to write.
start  input  1  begin execution at address 0; honoured only in IDLE or HALT.
instr_ready  input  1  consumer accepts instr this cycle.
instr  output  8  instruction to core; 8'h00 (NOP) whenever instr_valid=0.
instr_valid  output  1  instr holds a valid instruction.
pc  output  AW  address of next word to fetch.
busy  output  1  high in RUN state.
halted  output  1  high in HALT state.
instr_count  output  8  number of completed handshakes since last start; saturates at 255.

Behaviour:
- Reset values:
  - state=IDLE.
  - instr=8'h00, instr_valid=0.
  - pc=0, busy=0, halted=0, instr_count=0.
  - Memory contents are NOT reset; they survive rst.
- Word decode:
  - JMP: word[7:4]=4'hF; target = word[AW-1:0].
  - HALT: word = 8'h0F.
  - Everything else is passed to the core unchanged. This includes other 4'h0 words, which the core treats as NOP.
- States:
  - IDLE:
    - load_en writes memory.
    - start -> RUN; pc<=0, instr_count<=0.
  - RUN:
    - An advance is the condition (instr_valid=0) OR (instr_ready=1).
    - On an advance, read w=mem[pc] and act as follows:
      - w is HALT: state<=HALT, instr_valid<=0, instr<=8'h00, pc holds.
      - w is JMP: pc<=target, instr_valid<=0, instr<=8'h00 (one bubble per jump).
      - otherwise: instr<=w, instr_valid<=1, pc<=pc+1, wrapping DEPTH-1 -> 0.
    - With no advance, instr/instr_valid/pc hold (stall). instr must stay stable while valid and not ready.
  - HALT:
    - instr_valid=0, halted=1.
    - load_en writes memory.
    - start -> RUN with pc<=0, instr_count<=0.
- Handshake:
  - A transfer is instr_valid & instr_ready at a rising edge.
  - Each transfer increments instr_count (saturating at 255).
  - instr_ready while instr_valid=0 has no effect on the count.
- A word transferred in the same cycle that HALT is fetched is counted; halted rises the following cycle.
- Latency: start sampled at edge N; first instr_valid=1 after edge N+1.
- Full throughput with instr_ready held high: one instruction per cycle, except one bubble per JMP.
- Simultaneous load_en and start in IDLE/HALT:
  - The write completes at that edge.
  - The first fetch, one cycle later, sees the new contents.
- load_en and start in RUN are ignored; memory is unchanged.
- A JMP to itself bubbles indefinitely with instr_valid=0 and busy=1. This is legal; only rst exits it.
- rst mid-RUN or mid-stall:
  - All outputs return to reset values on that edge.
  - A pending instruction is dropped.

Test Plan:
- Load mem[0..3]={8'h10,8'h20,8'h30,8'h0F}, start, instr_ready=1 -> instr 8'h10,8'h20,8'h30 on three consecutive cycles starting 2 cycles after start; then halted=1, instr_count=3, pc=3.
- Same program with instr_ready=0 for 3 cycles while 8'h20 is valid -> 8'h20 stays stable and valid; pc=2; instr_count does not advance until ready; sequence then completes intact.
- Program mem[0]=8'h10, mem[1]=8'hF4, mem[4]=8'h90, mem[5]=8'h0F -> transfers 8'h10, one bubble (valid=0), then 8'h90, halt; instr_count=2.
- Fill all 16 words with 8'h50, except mem[15]=8'hF0 -> after 256 transfers instr_count stays 255; the stream continues via the wrap jump; pc cycles 0..15.
- Assert rst during RUN with valid=1 -> next cycle instr=8'h00, valid=0, pc=0, state IDLE; re-start replays the program from mem[0] (memory retained).
- In RUN, pulse load_en to addr 0 with 8'hE0 -> mem[0] unchanged (verified by re-start output). Then in HALT, assert load_en and start together with 8'hE0 -> first issued instr=8'hE0.
